muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply / divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on operand magnitudes, followed by a single sign-fix cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; done pulse (if any) is visible here
// CALC  | WIDTH iteration steps, counter counts down to terminal 0
// FIX   | apply sign correction / divide-by-zero result, write hi/lo
// DONE  | raise done and drop busy for the following cycle
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes at accept and one iteration step of each datapath.
    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    always_comb begin
        w_a_neg     = op[0] & a[WIDTH-1];
        w_b_neg     = op[0] & b[WIDTH-1];
        w_a_mag     = w_a_neg ? -a : a;
        w_b_mag     = w_b_neg ? -b : b;
        w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
        w_div_shift = {r_acc, r_mq[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
        w_div_sub   = w_div_shift[WIDTH-1:0] - r_mcand;
        w_prod      = {r_acc, r_mq};
        w_prod_neg  = -w_prod;
        w_quo_fix   = r_neg_q ? -r_mq : r_mq;
        w_rem_fix   = r_neg_r ? -r_acc : r_acc;
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_raw  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_CALC;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_div    <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (b == '0);
                        r_a_raw  <= a;
                        r_acc    <= '0;
                        if (op[1]) begin
                            r_mq    <= w_a_mag;
                            r_mcand <= w_b_mag;
                        end else begin
                            r_mq    <= w_b_mag;
                            r_mcand <= w_a_mag;
                        end
                    end
                end
                S_CALC: begin
                    if (r_div) begin
                        r_acc <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div) begin
                        if (r_b_zero) begin
                            r_hi  <= r_a_raw;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi  <= w_rem_fix;
                            r_lo  <= w_quo_fix;
                            r_dbz <= 1'b0;
                        end
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
                        r_dbz        <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue; a monitor pops
// and compares on every done pulse, including done latency from accept.
module tb_muldiv_unit;
    localparam int  W = 32;
    localparam time P = 10;
    localparam int  LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #(P/2) clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        time          t_acc;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 at %0t expected no pending op", $time);
            end else begin
                m_e = sb.pop_front();
                check($sformatf("op%0d_hi", m_e.id), 64'(hi), 64'(m_e.hi));
                check($sformatf("op%0d_lo", m_e.id), 64'(lo), 64'(m_e.lo));
                check($sformatf("op%0d_dbz", m_e.id), 64'(div_by_zero), 64'(m_e.dbz));
                check($sformatf("op%0d_latency", m_e.id),
                      64'(($time - P/2 - m_e.t_acc) / P), 64'(LAT));
            end
        end
    end

    task automatic issue(input int id, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ed, input bit expect_done);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        if (expect_done) begin
            e.hi    = eh;
            e.lo    = el;
            e.dbz   = ed;
            e.t_acc = $time;
            e.id    = id;
            sb.push_back(e);
        end
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for the done pulse; returns inside the done cycle.
    task automatic wait_done(input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check($sformatf("op%0d_done_seen", id), 64'(seen), 64'd1);
        if (!seen) sb.delete();
    endtask

    task automatic run(input int id, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic ed);
        issue(id, o, x, y, eh, el, ed, 1'b1);
        wait_done(id);
    endtask

    initial begin
        #(100000 * P);
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int d0;
        int busy_bad;
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // MULTU all-ones squared, with busy window checked cycle by cycle
        issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        busy_bad = 0;
        @(negedge clk);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (busy !== (k <= LAT - 1)) busy_bad++;
        end
        #1;
        check("busy_window_bad_cycles", 64'(busy_bad), 64'd0);
        check("op1_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);

        run(2,  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run(3,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(4,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run(5,  2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run(6,  2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        run(7,  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run(8,  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run(9,  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        // back-to-back: divide by zero then a multiply accepted right after done
        run(10, 2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run(11, 2'b00, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0);

        // start while busy is ignored
        d0 = n_done;
        issue(12, 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(12);
        repeat (2 * LAT) @(negedge clk);
        check("ignored_start_done_count", 64'(n_done - d0), 64'd1);
        check("ignored_start_lo", 64'(lo), 64'd30);

        // flush mid-operation: no done, results unchanged
        d0 = n_done;
        issue(13, 2'b00, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        repeat (2 * LAT) @(negedge clk);
        check("flush_done_count", 64'(n_done - d0), 64'd0);
        check("flush_hi_held", 64'(hi), 64'd0);
        check("flush_lo_held", 64'(lo), 64'd30);

        // flush and start together in IDLE: flush wins
        #1 start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (2 * LAT) @(negedge clk);
        check("flush_start_done_count", 64'(n_done - d0), 64'd0);

        // leave div_by_zero set, then reset in the middle of an operation
        #1;
        run(14, 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
        d0 = n_done;
        issue(15, 2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_dbz", 64'(div_by_zero), 64'd0);
        // start presented together with reset release: accepted on the next edge
        rst = 1'b1;
        run(16, 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        repeat (10) @(negedge clk);
        check("midrst_done_count", 64'(n_done - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
